// File: rtl/psum_drain_pkg.sv
// Shared defaults and FSM encoding for the partial-sum drain block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package psum_drain_pkg;

    localparam int PSUM_DATA_WIDTH = 16;
    localparam int PSUM_NUM_PE     = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/psum_row_buf.sv
// Row buffer: holds one full row of PE partial sums, loaded on i_load.
// Latency: one cycle from i_load to o_q.
// Backpressure: none; the owner decides when loading is allowed.
module psum_row_buf #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Capture the incoming row whenever a load is granted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/psum_drain.sv
// Latches a row of PE partial sums and streams it out one element per transfer.
// Latency: capture at cycle t gives element 0 valid at t+1; zero bubbles between rows.
// Backpressure: out_ready=0 holds the current element; captures while draining are dropped.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DATA_WIDTH,
    parameter int NUM_PE     = PSUM_NUM_PE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         capture,
    input  logic [NUM_PE*DATA_WIDTH-1:0] psum_row,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         drop_err
);

    localparam int                IDX_W    = $clog2(NUM_PE);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_PE - 1);

    drain_state_t                  r_state;
    drain_state_t                  w_next_state;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              w_next_idx;
    logic                          r_drop_err;
    logic                          w_drop;
    logic                          w_load;
    logic                          w_busy;
    logic                          w_xfer;
    logic                          w_is_last;
    logic [NUM_PE*DATA_WIDTH-1:0]  w_row;
    logic [DATA_WIDTH-1:0]         w_elem;

    psum_row_buf #(
        .WIDTH (NUM_PE*DATA_WIDTH)
    ) u_row_buf (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_load  (w_load),
        .i_d     (psum_row),
        .o_q     (w_row)
    );

    assign w_busy    = (r_state == ST_DRAIN);
    assign w_is_last = (r_idx == LAST_IDX);
    assign w_xfer    = w_busy & out_ready;

    // State, element index and drop pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_drop_err <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_idx      <= w_next_idx;
            r_drop_err <= w_drop;
        end
    end

    // Next state: accept a row when idle or on the final transfer, otherwise refuse it.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (capture) begin
                    w_next_state = ST_DRAIN;
                    w_next_idx   = '0;
                    w_load       = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_xfer && w_is_last) begin
                    w_next_idx = '0;
                    if (capture) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_next_idx = r_idx + IDX_W'(1);
                    end
                    if (capture) begin
                        w_drop = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_idx   = '0;
            end
        endcase
    end

    // Element select; forced to zero while nothing is held so stale rows never leak out.
    always_comb begin
        w_elem = '0;
        if (w_busy) begin
            for (int k = 0; k < NUM_PE; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    w_elem = w_row[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign busy      = w_busy;
    assign out_valid = w_busy;
    assign out_data  = w_elem;
    assign out_last  = w_busy & w_is_last;
    assign drop_err  = r_drop_err;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain with a scoreboard of expected elements.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: out_ready is toggled per scenario; every transfer pops the scoreboard.
module tb_psum_drain;

    localparam int DW = 16;
    localparam int NP = 4;

    logic               clk;
    logic               rst_n;
    logic               capture;
    logic [NP*DW-1:0]   psum_row;
    logic               out_ready;
    logic               out_valid;
    logic [DW-1:0]      out_data;
    logic               out_last;
    logic               busy;
    logic               drop_err;

    int errors = 0;
    int checks = 0;
    int n_xfer = 0;

    logic [DW:0] sb_q[$];

    localparam logic [NP*DW-1:0] ROW_A = {16'h0004, 16'hFFFD, 16'h7FFF, 16'h8000};
    localparam logic [NP*DW-1:0] ROW_B = {16'h1234, 16'hABCD, 16'h0001, 16'hFFFF};
    localparam logic [NP*DW-1:0] ROW_C = {16'hDEAD, 16'hBEEF, 16'h5555, 16'hAAAA};

    psum_drain #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (capture),
        .psum_row  (psum_row),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every transfer must match the oldest expected element.
    always @(negedge clk) begin
        logic [DW:0] exp_v;
        if (out_valid && out_ready) begin
            checks++;
            n_xfer++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_xfer: got data=%h last=%b, required no transfer", out_data, out_last);
            end else begin
                exp_v = sb_q.pop_front();
                if ({out_last, out_data} !== exp_v) begin
                    errors++;
                    $display("FAIL xfer_data: got last=%b data=%h, required last=%b data=%h",
                             out_last, out_data, exp_v[DW], exp_v[DW-1:0]);
                end
            end
        end
        if (!out_valid) begin
            checks++;
            if (out_data !== '0 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero: got data=%h last=%b, required 0 0", out_data, out_last);
            end
        end
    end

    task automatic push_row(input logic [NP*DW-1:0] row);
        for (int k = 0; k < NP; k++) begin
            sb_q.push_back({(k == NP-1), row[k*DW +: DW]});
        end
    endtask

    // Drive a capture for one cycle; returns 1ns after the capturing edge.
    task automatic do_capture(input logic [NP*DW-1:0] row);
        capture  = 1'b1;
        psum_row = row;
        push_row(row);
        @(posedge clk); #1;
        capture  = 1'b0;
        psum_row = '0;
    endtask

    task automatic check_sb_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_empty: got %0d pending, required 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; capture = 1'b0; psum_row = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({out_valid, out_last, busy, drop_err} !== 4'b0000 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b d=%b data=%h, required all 0",
                     out_valid, out_last, busy, drop_err, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        do_capture(ROW_A);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c <= 4) || busy !== (c <= 4)) begin
                errors++;
                $display("FAIL basic_valid c=%0d: got v=%b b=%b, required %b", c, out_valid, busy, (c <= 4));
            end
            if (c == 1) begin
                checks++;
                if (out_data !== 16'h8000) begin
                    errors++;
                    $display("FAIL basic_latency: got %h, required 8000", out_data);
                end
            end
            @(posedge clk); #1;
        end
        check_sb_empty("basic");
    endtask

    task automatic test_backpressure;
        int start_x;
        start_x   = n_xfer;
        out_ready = 1'b0;
        do_capture(ROW_A);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h8000 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold c=%0d: got v=%b data=%h l=%b, required 1 8000 0",
                         c, out_valid, out_data, out_last);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (n_xfer - start_x != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d transfers, required 4", n_xfer - start_x);
        end
        check_sb_empty("bp");
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        do_capture(ROW_A);
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (c <= 8)) begin
                errors++;
                $display("FAIL b2b_valid c=%0d: got %b, required %b", c, out_valid, (c <= 8));
            end
            if (c == 5) begin
                checks++;
                if (out_data !== 16'hFFFF || drop_err !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rowB_first: got data=%h drop=%b, required ffff 0", out_data, drop_err);
                end
            end
            @(posedge clk); #1;
            if (c == 3) begin
                capture  = 1'b1;
                psum_row = ROW_B;
                push_row(ROW_B);
            end else begin
                capture  = 1'b0;
                psum_row = '0;
            end
        end
        check_sb_empty("b2b");
    endtask

    task automatic test_drop;
        out_ready = 1'b1;
        do_capture(ROW_A);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            checks++;
            if (drop_err !== (c == 3)) begin
                errors++;
                $display("FAIL drop_pulse c=%0d: got %b, required %b", c, drop_err, (c == 3));
            end
            @(posedge clk); #1;
            if (c == 1) begin
                capture  = 1'b1;
                psum_row = ROW_C;
            end else begin
                capture  = 1'b0;
                psum_row = '0;
            end
        end
        check_sb_empty("drop");
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        do_capture(ROW_A);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL rstmid_immediate: got v=%b b=%b data=%h, required 0 0 0", out_valid, busy, out_data);
        end
        checks++;
        if (sb_q.size() != 2) begin
            errors++;
            $display("FAIL rstmid_xfers: got %0d pending, required 2", sb_q.size());
        end
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stay_idle c=%0d: got %b, required 0", c, out_valid);
            end
        end
        @(posedge clk); #1;
        do_capture(ROW_B);
        repeat (5) @(posedge clk);
        #1;
        check_sb_empty("rstmid_after");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_back_to_back;
        test_drop;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/psum_drain.md
PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one signed partial sum.
REQ-002 Parameter NUM_PE, default 4, number of PE partial sums per row; legal range 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 capture  input  1  one-cycle strobe; psum_row holds a valid row this cycle.
REQ-006 psum_row  input  NUM_PE*DATA_WIDTH  packed PE outputs; element k = bits [k*DATA_WIDTH +: DATA_WIDTH], signed.
REQ-007 out_ready  input  1  downstream can accept out_data this cycle.
REQ-008 out_valid  output  1  out_data/out_last are valid.
REQ-009 out_data  output  DATA_WIDTH  current signed element.
REQ-010 out_last  output  1  current element is index NUM_PE-1.
REQ-011 busy  output  1  a row is held and not yet fully drained.
REQ-012 drop_err  output  1  one-cycle pulse; a capture was refused.

Function
REQ-013 The FSM SHALL have two states: IDLE (no row held) and DRAIN (row held, streaming).
REQ-014 In IDLE with capture=1, the block SHALL latch psum_row, set idx=0 and enter DRAIN at the next edge.
REQ-015 Latency SHALL be one cycle: capture at cycle t gives out_valid=1 with element 0 at cycle t+1.
REQ-016 In DRAIN, out_valid SHALL be 1, out_data SHALL equal latched element idx, and out_last SHALL equal (idx==NUM_PE-1).
REQ-017 A transfer occurs when out_valid&out_ready; only a transfer SHALL advance idx by 1.
REQ-018 While out_valid=1 and out_ready=0, out_data, out_last and idx SHALL remain stable.
REQ-019 A transfer with out_last=1 and capture=0 SHALL return to IDLE; out_valid SHALL be 0 the next cycle.
REQ-020 A transfer with out_last=1 and capture=1 SHALL latch the new row, set idx=0 and stay in DRAIN, giving zero bubble cycles between rows.
REQ-021 A capture in DRAIN other than REQ-020 SHALL be ignored; the latched row SHALL be unchanged and drop_err SHALL pulse high the next cycle.
REQ-022 busy SHALL equal (state==DRAIN); out_valid SHALL equal busy.
REQ-023 Values SHALL pass through bit-exact with no sign extension, truncation or arithmetic.
REQ-024 idx SHALL be ceil(log2(NUM_PE)) bits wide and SHALL never exceed NUM_PE-1; there is no wrap past last.

Reset
REQ-025 Asserting rst_n low SHALL immediately force IDLE, idx=0, out_valid=0, out_last=0, busy=0, drop_err=0 and out_data=0.
REQ-026 Reset mid-drain SHALL discard the held row; elements not yet transferred SHALL never appear after reset.
REQ-027 The row buffer contents need not be reset, but out_data SHALL read 0 whenever out_valid=0.

Structure
REQ-028 A shared package SHALL hold DATA_WIDTH and NUM_PE defaults and the IDLE/DRAIN state encoding.
REQ-029 The row buffer SHALL be one sub-module, psum_row_buf: a NUM_PE*DATA_WIDTH register with load enable and asynchronous active-low reset.
REQ-030 The element select mux and FSM SHALL be inline in psum_drain.

Verification (NUM_PE=4, DATA_WIDTH=16)
REQ-031 Basic drain: capture row {0x0004,0xFFFD,0x7FFF,0x8000} (elements 3..0) with out_ready=1 -> out_data 0x8000,0x7FFF,0xFFFD,0x0004 on cycles t+1..t+4; out_last only on 0x0004; out_valid=0 at t+5.
REQ-032 Backpressure: same row, out_ready=0 for cycles t+1..t+3 then 1 -> out_data holds 0x8000 for those cycles, then sequence continues; exactly 4 transfers.
REQ-033 Back-to-back: capture row B on the last transfer of row A -> row B element 0 on the next cycle; out_valid never drops.
REQ-034 Dropped capture: capture row C while idx=1 -> drop_err=1 for one cycle; remaining outputs still come from row A.
REQ-035 Reset mid-drain: rst_n low after 2 transfers -> out_valid=0 immediately; after release, out_valid stays 0 until the next capture.
